// File: rtl/cpfifo_pkg.sv
// +--------------------------------------------------------------------+
// | cpfifo_pkg : shared state encoding for the cpfifo elastic buffer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpfifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_MID   = 2'b01,
        S_FULL  = 2'b11
    } cpfifo_state_t;

endpackage

`default_nettype wire

// File: rtl/cpfifo_ptr.sv
// +--------------------------------------------------------------------+
// | cpfifo_ptr : wrap-around pointer 0..DEPTH-1 with sync clear        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cpfifo_ptr #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          i_CLK,
    input  logic          i_RSTn,
    input  logic          i_ADV,
    input  logic          i_CLR,
    output logic [PW-1:0] o_PTR
);

    localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] c_ONE  = PW'(1);

    logic [PW-1:0] ptr_d;
    logic [PW-1:0] ptr_q;

    // Wrap on DEPTH-1 explicitly so non-power-of-two depths work.
    always_comb begin
        ptr_d = ptr_q;
        if (i_CLR) begin
            ptr_d = '0;
        end else if (i_ADV) begin
            ptr_d = (ptr_q == c_LAST) ? '0 : ptr_q + c_ONE;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_PTR = ptr_q;

endmodule

`default_nettype wire

// File: rtl/cpfifo.sv
// +--------------------------------------------------------------------+
// | cpfifo : DEPTH-entry READY-VALID elastic buffer, registered outputs |
// | Optional flush port enabled by macro CPFIFO_FLUSH_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module cpfifo
    import cpfifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
`ifdef CPFIFO_FLUSH_EN
    input  logic             i_FLUSH,
`endif
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_D,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [WIDTH-1:0] o_Q,
    output logic [CW-1:0]    o_COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] c_ONE       = CW'(1);
    localparam logic [CW-1:0] c_FULL_LESS = CW'(DEPTH - 1);

    cpfifo_state_t    state_q;
    cpfifo_state_t    state_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             flush;
    logic             push;
    logic             pop;

`ifdef CPFIFO_FLUSH_EN
    assign flush = i_FLUSH;
`else
    assign flush = 1'b0;
`endif

    // Handshake flags come from state only, so no input-to-output paths exist.
    always_comb begin
        o_VALID = 1'b0;
        o_READY = 1'b1;
        case (state_q)
            S_MID: begin
                o_VALID = 1'b1;
                o_READY = 1'b1;
            end
            S_FULL: begin
                o_VALID = 1'b1;
                o_READY = 1'b0;
            end
            default: begin
                o_VALID = 1'b0;
                o_READY = 1'b1;
            end
        endcase
    end

    assign push = i_VALID & o_READY & ~flush;
    assign pop  = o_VALID & i_READY & ~flush;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + c_ONE;
        end else if (pop && !push) begin
            count_d = count_q - c_ONE;
        end
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_MID;
                end
            end
            S_MID: begin
                if (push && !pop && (count_q == c_FULL_LESS)) begin
                    state_d = S_FULL;
                end else if (pop && !push && (count_q == c_ONE)) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    state_d = S_MID;
                end
            end
            default: begin
                state_d = S_EMPTY;
                count_d = '0;
            end
        endcase
        if (flush) begin
            state_d = S_EMPTY;
            count_d = '0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= S_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr] = i_D;
        end
    end

    // Storage is deliberately not reset; o_VALID qualifies o_Q.
    always_ff @(posedge i_CLK) begin
        mem_q <= mem_d;
    end

    cpfifo_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .i_ADV  (push),
        .i_CLR  (flush),
        .o_PTR  (wr_ptr)
    );

    cpfifo_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .i_ADV  (pop),
        .i_CLR  (flush),
        .o_PTR  (rd_ptr)
    );

    assign o_Q     = mem_q[rd_ptr];
    assign o_COUNT = count_q;

endmodule

`default_nettype wire

// File: tb/tb_cpfifo.sv
// +--------------------------------------------------------------------+
// | tb_cpfifo : scoreboard bench for cpfifo (WIDTH=8, DEPTH=4)         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cpfifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             i_CLK = 1'b0;
    logic             i_RSTn;
    logic             i_VALID;
    logic             o_READY;
    logic [WIDTH-1:0] i_D;
    logic             o_VALID;
    logic             i_READY;
    logic [WIDTH-1:0] o_Q;
    logic [CW-1:0]    o_COUNT;
`ifdef CPFIFO_FLUSH_EN
    logic             i_FLUSH;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] sb_q [$];

    cpfifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .i_CLK   (i_CLK),
        .i_RSTn  (i_RSTn),
`ifdef CPFIFO_FLUSH_EN
        .i_FLUSH (i_FLUSH),
`endif
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .i_D     (i_D),
        .o_VALID (o_VALID),
        .i_READY (i_READY),
        .o_Q     (o_Q),
        .o_COUNT (o_COUNT)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare all outputs against the scoreboard contents.
    task automatic check_outputs(input string tag);
        check({tag, ".count"}, 32'(o_COUNT), 32'(sb_q.size()));
        check({tag, ".valid"}, 32'(o_VALID), 32'(sb_q.size() != 0));
        check({tag, ".ready"}, 32'(o_READY), 32'(sb_q.size() < DEPTH));
        if (sb_q.size() != 0) begin
            check({tag, ".q"}, 32'(o_Q), 32'(sb_q[0]));
        end
    endtask

    // Model the edge from the bench's own view of occupancy, then sample.
    task automatic cycle(input string tag);
        bit m_push;
        bit m_pop;
        logic [WIDTH-1:0] dummy;
        m_push = i_VALID && (sb_q.size() < DEPTH);
        m_pop  = i_READY && (sb_q.size() != 0);
`ifdef CPFIFO_FLUSH_EN
        if (i_FLUSH) begin
            m_push = 1'b0;
            m_pop  = 1'b0;
            sb_q.delete();
        end
`endif
        if (m_pop) dummy = sb_q.pop_front();
        if (m_push) sb_q.push_back(i_D);
        @(posedge i_CLK);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        i_RSTn  = 1'b0;
        i_VALID = 1'b0;
        i_READY = 1'b0;
        i_D     = '0;
`ifdef CPFIFO_FLUSH_EN
        i_FLUSH = 1'b0;
`endif
        #1;
        check_outputs("reset");
        #22;
        i_RSTn = 1'b1;
        @(posedge i_CLK);
        #1;

        // Idle with i_READY toggling: nothing may change.
        for (int i = 0; i < 10; i++) begin
            i_READY = i[0];
            cycle("idle");
        end

        // Fill with downstream stalled, then offer a 5th value.
        i_READY = 1'b0;
        i_VALID = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            i_D = 8'(i * 8'h11);
            cycle("fill");
        end
        i_D = 8'h55;
        for (int i = 0; i < 3; i++) cycle("full_hold");

        // Release downstream with 0x55 still offered.
        i_READY = 1'b1;
        cycle("full_pop");
        check("full_pop.count3", 32'(o_COUNT), 32'd3);
        cycle("push_pop");
        i_VALID = 1'b0;
        for (int i = 0; i < 5; i++) cycle("drain");
        check("drain.empty", 32'(o_COUNT), 32'd0);

        // Continuous stream, one transfer per cycle.
        i_VALID = 1'b1;
        i_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_D = 8'(i);
            cycle("stream");
            check("stream.count1", 32'(o_COUNT), 32'd1);
        end
        i_VALID = 1'b0;
        cycle("stream_end");

        // Reset mid-stream with three entries held.
        i_READY = 1'b0;
        i_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_D = 8'(8'hA0 + i);
            cycle("pre_rst");
        end
        i_VALID = 1'b0;
        #2;
        i_RSTn = 1'b0;
        sb_q.delete();
        #1;
        check_outputs("async_rst");
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        @(posedge i_CLK);
        #1;
        check_outputs("post_rst");
        i_VALID = 1'b1;
        i_D     = 8'hA5;
        cycle("rst_push");
        i_VALID = 1'b0;
        check("rst_push.first", 32'(o_Q), 32'h0000_00A5);
        i_READY = 1'b1;
        cycle("rst_pop");

`ifdef CPFIFO_FLUSH_EN
        // Flush with simultaneous push and pop.
        i_READY = 1'b0;
        i_VALID = 1'b1;
        i_D = 8'h61; cycle("pre_flush");
        i_D = 8'h62; cycle("pre_flush");
        check("pre_flush.count2", 32'(o_COUNT), 32'd2);
        i_READY = 1'b1;
        i_D     = 8'h77;
        i_FLUSH = 1'b1;
        cycle("flush");
        check("flush.count0", 32'(o_COUNT), 32'd0);
        i_FLUSH = 1'b0;
        i_VALID = 1'b0;
        for (int i = 0; i < 3; i++) cycle("post_flush");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
